pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/cpu_pkg.sv | 7 +
 rtl/hazard_detect.sv | 16 +
 rtl/pipe_ctrl.sv | 77 +++++++
 tb/tb_pipe_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline-control state encoding and parameter defaults
package cpu_pkg;
  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED, ERROR} state_t;
  localparam int REG_W_DEF = 4;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard compare between ID/EX load and IF/ID sources
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  output logic             load_use
);
  assign load_use = idex_memread && idex_rd != '0 &&
                    (idex_rd == ifid_rs || (ifid_uses_rt && idex_rd == ifid_rt));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with memory-wait FSM and stall counter
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             exmem_memacc,
  input  logic             dmem_ready,
  input  logic             memwb_halt,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             idex_wen,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             dmem_req,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  state_t state, next;
  logic [WC_W-1:0] wcnt;
  logic lu, active, halt_now, mstall, go;
  hazard_detect #(.REG_W(REG_W)) u_hd (
    .idex_memread(idex_memread),
    .idex_rd(idex_rd),
    .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt),
    .load_use(lu)
  );
  always_comb begin
    active = state == RUN || state == MEMWAIT;
    halt_now = state == RUN && memwb_halt;
    mstall = !dmem_ready && (state == MEMWAIT || (state == RUN && exmem_memacc));
    go = active && !halt_now && !mstall && !rst;
    pc_wen = go && !lu;
    ifid_wen = go && !lu;
    idex_wen = go;
    exmem_wen = go;
    memwb_wen = go;
    ifid_flush = rst || (go && !lu && branch_taken);
    idex_flush = rst || (go && lu);
    memwb_flush = rst || (mstall && !halt_now);
    dmem_req = !rst && active && exmem_memacc;
    next = state;
    if (halt_now) next = HALTED;
    else if (mstall) next = (state == RUN) ? MEMWAIT : (wcnt == WC_W'(MEM_TIMEOUT - 1)) ? ERROR : MEMWAIT;
    else if (state == MEMWAIT) next = RUN;
  end
  // wait counter restarts every time the FSM leaves MEMWAIT
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      wcnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= next;
      wcnt <= (state == MEMWAIT) ? wcnt + 1'b1 : '0;
      if (active && !pc_wen && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  assign halted = state == HALTED;
  assign err = state == ERROR;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
  localparam int RW = 4, TO = 4, CW = 4;
  logic clk = 0, rst = 1;
  logic idex_memread, ifid_uses_rt, branch_taken, exmem_memacc, dmem_ready, memwb_halt;
  logic [RW-1:0] idex_rd, ifid_rs, ifid_rt;
  logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
  logic ifid_flush, idex_flush, memwb_flush, dmem_req, halted, err;
  logic [CW-1:0] stall_cnt;
  logic [8:0] ov;
  int n_chk = 0, n_pass = 0;
  int m_mode = 0, m_wait = 0, m_stall = 0;
  always #5 clk = ~clk;
  pipe_ctrl #(.REG_W(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken), .exmem_memacc(exmem_memacc),
    .dmem_ready(dmem_ready), .memwb_halt(memwb_halt),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen), .exmem_wen(exmem_wen),
    .memwb_wen(memwb_wen), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .dmem_req(dmem_req), .halted(halted), .err(err),
    .stall_cnt(stall_cnt)
  );
  assign ov = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, memwb_flush, dmem_req};
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  // mode: 0 running, 1 waiting on memory, 2 halted, 3 error
  function automatic logic [8:0] model_out();
    logic lu;
    lu = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs || (ifid_uses_rt && idex_rd == ifid_rt));
    if (rst) return 9'b00000_111_0;
    if (m_mode >= 2) return '0;
    if (m_mode == 0 && memwb_halt) return {8'b0, exmem_memacc};
    if (!dmem_ready && (m_mode == 1 || exmem_memacc)) return {8'b00000_001, exmem_memacc};
    if (lu) return {8'b00111_010, exmem_memacc};
    if (branch_taken) return {8'b11111_100, exmem_memacc};
    return {8'b11111_000, exmem_memacc};
  endfunction
  task automatic model_update(input logic [8:0] e);
    if (m_mode < 2 && !e[8] && m_stall < (1 << CW) - 1) m_stall++;
    if (m_mode == 0 && memwb_halt) m_mode = 2;
    else if (m_mode < 2 && !dmem_ready && (m_mode == 1 || exmem_memacc)) begin
      if (m_mode == 0) begin
        m_mode = 1;
        m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == TO) m_mode = 3;
      end
    end else if (m_mode == 1) m_mode = 0;
  endtask
  task automatic step();
    logic [8:0] e;
    #3;
    e = model_out();
    check("outs", ov, e);
    check("halted", halted, m_mode == 2);
    check("err", err, m_mode == 3);
    check("stall_cnt", stall_cnt, m_stall);
    @(posedge clk);
    model_update(e);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_outs", ov, 9'b00000_1110);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall_cnt, 0);
    rst = 0;
    m_mode = 0;
    m_wait = 0;
    m_stall = 0;
    #1;
  endtask
  task automatic set_in(input logic mr, input int rd, input int rs, input int rt, input logic ut,
                        input logic br, input logic ma, input logic rdy, input logic h);
    idex_memread = mr;
    idex_rd = RW'(rd);
    ifid_rs = RW'(rs);
    ifid_rt = RW'(rt);
    ifid_uses_rt = ut;
    branch_taken = br;
    exmem_memacc = ma;
    dmem_ready = rdy;
    memwb_halt = h;
  endtask
  task automatic rand_in();
    set_in(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
  endtask
  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    do_reset();
    set_in(1, 3, 3, 0, 0, 0, 0, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    step();
    set_in(1, 0, 0, 0, 1, 0, 0, 1, 0);
    step();
    check("rd0_pc_wen", pc_wen, 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) step();
    dmem_ready = 1;
    step();
    check("memwait_stall_cnt", stall_cnt, 4);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    set_in(1, 3, 3, 0, 0, 1, 0, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 1, 0, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("halt_halted", halted, 1);
    step();
    #2;
    do_reset();
    check("post_rst_pc_wen", pc_wen, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (5) step();
    check("timeout_err", err, 1);
    repeat (3) begin
      rand_in();
      step();
    end
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) step();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    repeat (3000) begin
      rand_in();
      step();
      if ((m_mode >= 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) do_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
